// File: rtl/audio_frame_fifo_if.sv
// rtl/audio_frame_fifo_if.sv - frame write/read, status and interrupt signals of audio_frame_fifo
interface audio_frame_fifo_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int DEPTH_LOG2   = 4
);
  logic [SAMPLE_WIDTH-1:0] wr_l;
  logic [SAMPLE_WIDTH-1:0] wr_r;
  logic                    wr_valid;
  logic                    wr_full;
  logic [SAMPLE_WIDTH-1:0] rd_l;
  logic [SAMPLE_WIDTH-1:0] rd_r;
  logic                    rd_valid;
  logic                    rd_full;
  logic [DEPTH_LOG2:0]     level;
  logic                    overflow;
  logic [15:0]             underrun_cnt;
  logic                    clr_status;
  logic                    irq_low;

  modport slave (
    input  wr_l, wr_r, wr_valid, rd_full, clr_status,
    output wr_full, rd_l, rd_r, rd_valid, level, overflow, underrun_cnt, irq_low
  );

  modport master (
    output wr_l, wr_r, wr_valid, rd_full, clr_status,
    input  wr_full, rd_l, rd_r, rd_valid, level, overflow, underrun_cnt, irq_low
  );
endinterface

// File: rtl/audio_frame_fifo.sv
// rtl/audio_frame_fifo.sv - stereo frame FIFO between bus audio registers and the I2S master
// Optional level-low interrupt enabled by defining AUDIO_FIFO_IRQ_LOW_EN.
module audio_frame_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int SAMPLE_WIDTH  = 24,
  parameter int LOW_WATERMARK = 4
) (
  input logic               clk,
  input logic               reset,
  audio_frame_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

  if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 8 || LOW_WATERMARK < 0 || LOW_WATERMARK >= DEPTH) begin : g_bad_param
    $error("audio_frame_fifo: DEPTH_LOG2 or LOW_WATERMARK out of range");
  end

  typedef logic [2*SAMPLE_WIDTH-1:0] frame_t;

  frame_t                  mem_q [DEPTH];
  frame_t                  rd_frame;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    wr_full_q, wr_full_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [SAMPLE_WIDTH-1:0] rd_l_q, rd_l_d;
  logic [SAMPLE_WIDTH-1:0] rd_r_q, rd_r_d;
  logic                    overflow_q, overflow_d;
  logic                    starved_q, starved_d;
  logic [15:0]             underrun_q, underrun_d;
  logic                    wr_accept;
  logic                    wr_drop;
  logic                    pop;
  logic                    starve_rise;

  // Pops are blocked while rd_valid is high so the I2S full flag gets a cycle to react.
  always_comb begin
    wr_accept   = bus.wr_valid && (level_q != DEPTH_LVL);
    wr_drop     = bus.wr_valid && (level_q == DEPTH_LVL);
    pop         = (level_q != '0) && !bus.rd_full && !rd_valid_q;
    rd_frame    = mem_q[rd_ptr_q];

    wr_ptr_d    = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({wr_accept, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    wr_full_d   = (level_d == DEPTH_LVL);

    rd_valid_d  = pop;
    rd_l_d      = pop ? rd_frame[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH] : rd_l_q;
    rd_r_d      = pop ? rd_frame[SAMPLE_WIDTH-1:0] : rd_r_q;

    starved_d   = (level_q == '0) && !bus.rd_full;
    starve_rise = starved_d && !starved_q;

    // A set/increment event in the clear cycle wins over the clear.
    overflow_d = overflow_q;
    if (bus.clr_status) overflow_d = 1'b0;
    if (wr_drop)        overflow_d = 1'b1;

    underrun_d = underrun_q;
    if (bus.clr_status) underrun_d = '0;
    if (starve_rise) begin
      if (bus.clr_status)               underrun_d = 16'd1;
      else if (underrun_q != 16'hFFFF)  underrun_d = underrun_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= {bus.wr_l, bus.wr_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wr_full_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_l_q     <= '0;
      rd_r_q     <= '0;
      overflow_q <= 1'b0;
      starved_q  <= 1'b0;
      underrun_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      wr_full_q  <= wr_full_d;
      rd_valid_q <= rd_valid_d;
      rd_l_q     <= rd_l_d;
      rd_r_q     <= rd_r_d;
      overflow_q <= overflow_d;
      starved_q  <= starved_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef AUDIO_FIFO_IRQ_LOW_EN
  localparam logic [LW-1:0] WM_LVL = LW'(LOW_WATERMARK);

  logic armed_q, armed_d;
  logic irq_low_q, irq_low_d;

  // Interrupt stays quiet until the buffer has once been filled above the watermark.
  always_comb begin
    armed_d   = armed_q || (level_d > WM_LVL);
    irq_low_d = armed_d && (level_d <= WM_LVL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q   <= 1'b0;
      irq_low_q <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      irq_low_q <= irq_low_d;
    end
  end

  assign bus.irq_low = irq_low_q;
`else
  assign bus.irq_low = 1'b0;
`endif

  assign bus.wr_full      = wr_full_q;
  assign bus.rd_l         = rd_l_q;
  assign bus.rd_r         = rd_r_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underrun_cnt = underrun_q;
endmodule

// File: doc/audio_frame_fifo.md
# audio_frame_fifo

Stereo frame buffer between the CPU-side Wishbone audio registers and the I2S master. Frames written by software through the bus logic are queued here and drained into the I2S master's input whenever it is not full. Software can therefore write bursts of frames instead of polling per sample. The block also reports fill level, dropped writes and playback starvation.

## Interface
Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth in frames; depth = 2**DEPTH_LOG2 (range 2..8)
- SAMPLE_WIDTH, 24, bits per channel sample
- LOW_WATERMARK, 4, level at or below which `irq_low` asserts (only with the macro; 0..depth-1)

Ports:
- clk  in  1  SoC clock (clk_soc domain)
- reset  in  1  synchronous, active-high reset
- wr_l  in  SAMPLE_WIDTH  left sample from bus logic
- wr_r  in  SAMPLE_WIDTH  right sample from bus logic
- wr_valid  in  1  one-cycle write strobe; one frame per asserted cycle
- wr_full  out  1  FIFO holds depth frames (feeds bus-logic full flag)
- rd_l  out  SAMPLE_WIDTH  left sample to I2S master frame input
- rd_r  out  SAMPLE_WIDTH  right sample to I2S master frame input
- rd_valid  out  1  one-cycle write strobe to I2S master
- rd_full  in  1  I2S master input full
- level  out  DEPTH_LOG2+1  frames currently stored (0..depth)
- overflow  out  1  sticky: a write was dropped
- underrun_cnt  out  16  saturating count of starvation episodes
- clr_status  in  1  clears `overflow` and `underrun_cnt`
- irq_low  out  1  level-low interrupt (tied 0 without the macro)

## Operation
- Storage: 2**DEPTH_LOG2 entries of {l,r}; write and read pointers DEPTH_LOG2 bits wrap modulo depth; `level` is a separate registered counter.
- Write: on `wr_valid` with `level` < depth, store the frame at wr_ptr and increment wr_ptr. On `wr_valid` with `level` == depth, drop the frame, leave the pointers unchanged, and set `overflow`. A pop in the same cycle does not rescue the write.
- Pop condition (evaluated each cycle): `level` != 0 and !`rd_full` and !`rd_valid`. On a pop, register `rd_l`/`rd_r` from mem[rd_ptr], set `rd_valid`=1 for exactly one cycle, and increment rd_ptr. This gives at most one pop every two cycles, so the I2S `full` has a cycle to update.
- Level update: accepted write only → +1; pop only → -1; both → unchanged.
- Starvation: internal flag `starved` = (`level`==0 and !`rd_full`), registered. `underrun_cnt` increments on its 0→1 transition and saturates at 16'hFFFF.
- Status clear: `clr_status` clears `overflow` and `underrun_cnt`. If a set or increment event occurs in the same cycle, the event wins: `overflow`=1, or `underrun_cnt`=1.
- `rd_l`/`rd_r` hold their last value while `rd_valid`=0.

## Timing
- All outputs are registered.
- Reset values: `wr_full`=0, `rd_l`=0, `rd_r`=0, `rd_valid`=0, `level`=0, `overflow`=0, `underrun_cnt`=0, `irq_low`=0. Both pointers and `starved` reset to 0.
- Reset mid-operation empties the FIFO; stored frames are discarded and no `rd_valid` is issued in the cycle after reset.
- `wr_full` and `level` reflect a write one cycle after the `wr_valid` cycle.
- Latency into an empty FIFO with `rd_full`=0: `wr_valid` in cycle N → `rd_valid` in cycle N+2.
- Sustained drain rate: one frame per 2 cycles while `rd_full`=0.
- Memory may be distributed RAM with a registered output stage; no read-during-write hazard, because pops never read the slot being written when `level`=0.

## Configuration
- Macro AUDIO_FIFO_IRQ_LOW_EN.
- Defined: `irq_low` is registered and equals (`level` <= LOW_WATERMARK) once the FIFO has been filled above LOW_WATERMARK at least once since reset. This prevents an IRQ storm before playback starts. The arming flag is cleared by reset.
- Undefined: `irq_low` is constant 0, no watermark or arming logic is synthesized, and LOW_WATERMARK is ignored.

## Test plan
- Reset, then write 3 frames (L=0x000001..3, R=0x100001..3) with `rd_full`=1 → `level`=3, no `rd_valid`. Release `rd_full` → three `rd_valid` pulses every 2 cycles carrying the frames in order; `level` ends at 0.
- `rd_full`=1, write 17 frames at depth 16 → `wr_full`=1 after the 16th; the 17th is dropped and `overflow`=1. Drain and confirm frames 1..16 only. Pulse `clr_status` → `overflow`=0.
- Write and pop in the same cycle at `level`=5 → `level` stays 5; pointer wrap is verified by 40 streamed frames with no data corruption.
- Empty FIFO with `rd_full`=0 for 10 cycles → `underrun_cnt`=1 (not 10). Write one frame, let it drain, stay empty → `underrun_cnt`=2.
- With AUDIO_FIFO_IRQ_LOW_EN, LOW_WATERMARK=4: fill to 8, drain → `irq_low` rises when `level` reaches 4. A fresh reset with only 3 frames written → `irq_low` stays 0.
- Assert `reset` while 6 frames are queued and a `rd_valid` is pending → the next cycle shows all outputs at reset values and no further `rd_valid`.
